// File: rtl/ball_scheduler_pkg.sv
// Shared game constants: ball count defaults, game-controller state codes
// and the ball scheduler state encoding.
package ball_scheduler_pkg;

  localparam int NUM_BALLS_DEFAULT = 5;
  localparam int IDX_W_DEFAULT     = 3;

  typedef enum logic [2:0] {
    GC_RESET      = 3'd0,
    GC_WAIT_SHOT  = 3'd1,
    GC_AIM        = 3'd2,
    GC_MOVE_BALLS = 3'd3,
    GC_SCORE      = 3'd4,
    GC_GAME_OVER  = 3'd5
  } gc_state_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FRIC      = 3'd1,
    FRIC_WAIT = 3'd2,
    COLL      = 3'd3,
    COLL_WAIT = 3'd4,
    FINISH    = 3'd5
  } sched_state_t;

endpackage

// File: rtl/ball_scheduler_pair.sv
// pair_counter: walks ball pairs (a,b) with a<b in lexicographic order and
// flags the final pair so the scheduler knows when the collision sweep ends.
module pair_counter
  import ball_scheduler_pkg::*;
#(
  parameter int NUM_BALLS = NUM_BALLS_DEFAULT,
  parameter int IDX_W     = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_idx_a,
  output logic [IDX_W-1:0] o_idx_b,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(NUM_BALLS - 1);
  localparam logic [IDX_W-1:0] LAST_A  = IDX_W'(NUM_BALLS - 2);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);

  logic [IDX_W-1:0] r_idx_a;
  logic [IDX_W-1:0] r_idx_b;
  logic             w_last;

  assign w_last = (r_idx_a == LAST_A) && (r_idx_b == LAST_B);

  // Advancing past the final pair is blocked so the indices never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx_a <= '0;
      r_idx_b <= '0;
    end else if (i_clear) begin
      r_idx_a <= '0;
      r_idx_b <= IDX_ONE;
    end else if (i_advance && !w_last) begin
      if (r_idx_b == LAST_B) begin
        r_idx_a <= r_idx_a + IDX_ONE;
        r_idx_b <= r_idx_a + IDX_TWO;
      end else begin
        r_idx_b <= r_idx_b + IDX_ONE;
      end
    end
  end

  assign o_idx_a = r_idx_a;
  assign o_idx_b = r_idx_b;
  assign o_last  = w_last;

endmodule

// File: rtl/ball_scheduler.sv
// ball_scheduler: once per video frame, runs friction on every ball and a
// collision check on every ball pair, then reports whether all balls rest.
module ball_scheduler
  import ball_scheduler_pkg::*;
#(
  parameter int NUM_BALLS = NUM_BALLS_DEFAULT,
  parameter int IDX_W     = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             enable,
  output logic             fric_req,
  output logic [IDX_W-1:0] fric_idx,
  input  logic             fric_ack,
  input  logic             ball_moving,
  output logic             coll_req,
  output logic [IDX_W-1:0] coll_idx_a,
  output logic [IDX_W-1:0] coll_idx_b,
  input  logic             coll_ack,
  input  logic             coll_hit,
  output logic             busy,
  output logic             done_fric_all,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic             r_fric_req;
  logic             r_coll_req;
  logic [IDX_W-1:0] r_fric_idx;
  logic             r_moving_any;
  logic             r_done;
  logic             r_overrun;
  logic             r_abort;

  logic             w_abort;
  logic             w_start;
  logic             w_fric_issue;
  logic             w_fric_done;
  logic             w_fric_adv;
  logic             w_coll_issue;
  logic             w_coll_done;
  logic             w_pair_clear;
  logic             w_pair_adv;
  logic             w_last_pair;
  logic [IDX_W-1:0] w_idx_a;
  logic [IDX_W-1:0] w_idx_b;

  pair_counter #(
    .NUM_BALLS (NUM_BALLS),
    .IDX_W     (IDX_W)
  ) u_pair (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_pair_clear),
    .i_advance (w_pair_adv),
    .o_idx_a   (w_idx_a),
    .o_idx_b   (w_idx_b),
    .o_last    (w_last_pair)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FRIC/COLL are the issue cycles that raise req; the *_WAIT states hold it
  // until ack, so every transaction is separated by at least one low cycle.
  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_fric_issue = 1'b0;
    w_fric_done  = 1'b0;
    w_fric_adv   = 1'b0;
    w_coll_issue = 1'b0;
    w_coll_done  = 1'b0;
    w_pair_clear = 1'b0;
    w_pair_adv   = 1'b0;
    w_abort      = r_abort || !enable;
    case (r_state)
      IDLE: begin
        if (enable && frame_start) begin
          w_start = 1'b1;
          w_next  = FRIC;
        end
      end
      FRIC: begin
        if (w_abort) begin
          w_next = IDLE;
        end else begin
          w_fric_issue = 1'b1;
          w_next       = FRIC_WAIT;
        end
      end
      FRIC_WAIT: begin
        if (fric_ack) begin
          w_fric_done = 1'b1;
          if (w_abort) begin
            w_next = IDLE;
          end else if (r_fric_idx == LAST_IDX) begin
            w_pair_clear = 1'b1;
            w_next       = COLL;
          end else begin
            w_fric_adv = 1'b1;
            w_next     = FRIC;
          end
        end
      end
      COLL: begin
        if (w_abort) begin
          w_next = IDLE;
        end else begin
          w_coll_issue = 1'b1;
          w_next       = COLL_WAIT;
        end
      end
      COLL_WAIT: begin
        if (coll_ack) begin
          w_coll_done = 1'b1;
          if (w_abort) begin
            w_next = IDLE;
          end else if (w_last_pair) begin
            w_next = FINISH;
          end else begin
            w_pair_adv = 1'b1;
            w_next     = COLL;
          end
        end
      end
      FINISH: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fric_req   <= 1'b0;
      r_coll_req   <= 1'b0;
      r_fric_idx   <= '0;
      r_moving_any <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      if (w_fric_issue) begin
        r_fric_req <= 1'b1;
      end else if (w_fric_done) begin
        r_fric_req <= 1'b0;
      end

      if (w_coll_issue) begin
        r_coll_req <= 1'b1;
      end else if (w_coll_done) begin
        r_coll_req <= 1'b0;
      end

      if (w_start) begin
        r_fric_idx <= '0;
      end else if (w_fric_adv && (r_fric_idx != LAST_IDX)) begin
        r_fric_idx <= r_fric_idx + IDX_ONE;
      end

      if (w_start) begin
        r_moving_any <= 1'b0;
      end else if (w_fric_done) begin
        r_moving_any <= r_moving_any | ball_moving;
      end else if (w_coll_done) begin
        r_moving_any <= r_moving_any | coll_hit;
      end

      // Result only updates at the end of a completed pass or when the
      // controller leaves MOVE_BALLS.
      if (!enable) begin
        r_done <= 1'b0;
      end else if (r_state == FINISH) begin
        r_done <= !r_moving_any;
      end

      r_overrun <= frame_start && (r_state != IDLE);

      if (w_start) begin
        r_abort <= 1'b0;
      end else if ((r_state != IDLE) && !enable) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign fric_req      = r_fric_req;
  assign fric_idx      = r_fric_idx;
  assign coll_req      = r_coll_req;
  assign coll_idx_a    = w_idx_a;
  assign coll_idx_b    = w_idx_b;
  assign busy          = (r_state != IDLE);
  assign done_fric_all = r_done;
  assign overrun       = r_overrun;

endmodule

// File: doc/ball_scheduler.md
BALL_SCHEDULER -- requirements
Module: ball_scheduler

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 5, number of balls (cue + 2 stripes + 2 solid), legal range 2..8.
REQ-002 SHALL have parameter IDX_W, default 3, ball-index width.
REQ-003 SHALL have port clk  in  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_start  in  1  one-cycle pulse per video frame.
REQ-006 SHALL have port enable  in  1  high while the game controller is in a MOVE_BALLS state.
REQ-007 SHALL have port fric_req  out  1  friction-update request to the shared friction unit.
REQ-008 SHALL have port fric_idx  out  IDX_W  ball index for fric_req.
REQ-009 SHALL have ports fric_ack  in  1  friction done, and ball_moving  in  1  ball still has velocity (valid with fric_ack).
REQ-010 SHALL have port coll_req  out  1  collision-check request to the shared collision unit.
REQ-011 SHALL have ports coll_idx_a and coll_idx_b  out  IDX_W  ball pair for coll_req.
REQ-012 SHALL have ports coll_ack  in  1  check done, and coll_hit  in  1  pair collided (valid with coll_ack).
REQ-013 SHALL have port busy  out  1  high whenever not IDLE.
REQ-014 SHALL have port done_fric_all  out  1  all balls at rest (consumed by the game controller).
REQ-015 SHALL have port overrun  out  1  one-cycle pulse on a dropped frame_start.

Function
REQ-016 SHALL implement states IDLE, FRIC, FRIC_WAIT, COLL, COLL_WAIT, FINISH.
REQ-017 SHALL, in IDLE with enable=1 and frame_start=1, clear moving_any, set index to 0 and enter FRIC; fric_req high the next cycle.
REQ-018 SHALL hold req high with stable indices from FRIC/COLL through the *_WAIT state until ack is sampled high; req SHALL drop the cycle after ack, with at least one low cycle between transactions.
REQ-019 SHALL OR ball_moving into moving_any on every fric_ack; ack while req low SHALL be ignored.
REQ-020 SHALL sweep fric_idx 0..NUM_BALLS-1 in order, then enter COLL with a=0, b=1.
REQ-021 SHALL step pairs lexicographically (b++; at b=NUM_BALLS-1: a++, b=a+1), NUM_BALLS*(NUM_BALLS-1)/2 checks, always a<b.
REQ-022 SHALL OR coll_hit into moving_any on every coll_ack.
REQ-023 SHALL, after the final pair (a=NUM_BALLS-2, b=NUM_BALLS-1), enter FINISH for one cycle, then return to IDLE.
REQ-024 SHALL, in FINISH with enable=1, set done_fric_all=!moving_any.
REQ-025 SHALL clear done_fric_all in any cycle enable=0; done_fric_all changes only in FINISH or on enable=0.
REQ-026 SHALL ignore frame_start when not IDLE and pulse overrun the following cycle; no frame is queued.
REQ-027 SHALL, on enable falling mid-pass, complete any outstanding handshake and then return to IDLE without entering FINISH.
REQ-028 SHALL ignore frame_start in IDLE when enable=0, with no overrun pulse.
REQ-029 SHALL keep index counters IDX_W wide with no wrap past NUM_BALLS-1.

Reset
REQ-030 SHALL, on reset_n low, asynchronously force IDLE; fric_req, coll_req, busy, done_fric_all, overrun, moving_any=0; all indices=0.
REQ-031 SHALL, on reset_n assertion mid-handshake, drop req immediately and resume only on a fresh frame_start after release.

Structure
REQ-032 SHALL take state encodings and the NUM_BALLS default from the shared game-constants package, alongside the game-controller state codes.
REQ-033 SHALL use a single sub-module, pair_counter, for the (a,b) sequencing and last-pair flag.

Verification (NUM_BALLS=5, acks one cycle after req)
REQ-034 SHALL cover: enable=1, frame_start, ball_moving=0, coll_hit=0 -> fric_idx 0..4, then 10 pairs (0,1)..(3,4) in order, FINISH, done_fric_all=1.
REQ-035 SHALL cover: same pass but ball_moving=1 on ball 2 only -> done_fric_all stays 0; next pass all 0 -> done_fric_all=1.
REQ-036 SHALL cover: coll_hit=1 on pair (1,3) only -> done_fric_all=0 for that frame.
REQ-037 SHALL cover: frame_start during COLL_WAIT -> overrun one-cycle pulse, pair sequence undisturbed.
REQ-038 SHALL cover: enable drops while fric_req is waiting, fric_ack 4 cycles later -> req held until ack, then IDLE, done_fric_all=0, no FINISH.
REQ-039 SHALL cover: reset_n low mid-COLL -> all outputs 0 asynchronously; after release, no req until frame_start.
